// File: rtl/countdown_sequencer_pkg.sv
// Shared types and helpers for the egg-timer countdown sequencer.
// Holds the FSM state encoding, the MM:SS BCD digit record, and the
// pure-combinational load clamp and BCD borrow-decrement functions.
package countdown_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOADED = 3'd1,
    ST_RUN    = 3'd2,
    ST_PAUSE  = 3'd3,
    ST_ALARM  = 3'd4
  } state_t;

  localparam logic [3:0] BCD_MAX_UNITS    = 4'd9;
  localparam logic [3:0] BCD_MAX_TENS_SEC = 4'd5;

  typedef struct packed {
    logic [3:0] m1;
    logic [3:0] m0;
    logic [3:0] s1;
    logic [3:0] s0;
  } mmss_t;

  function automatic logic [3:0] clamp_bcd(input logic [3:0] d, input logic [3:0] max);
    return (d > max) ? max : d;
  endfunction

  // Non-BCD set values saturate; seconds-tens tops out at 5.
  function automatic mmss_t clamp_mmss(input mmss_t v);
    mmss_t r;
    r.m1 = clamp_bcd(v.m1, BCD_MAX_UNITS);
    r.m0 = clamp_bcd(v.m0, BCD_MAX_UNITS);
    r.s1 = clamp_bcd(v.s1, BCD_MAX_TENS_SEC);
    r.s0 = clamp_bcd(v.s0, BCD_MAX_UNITS);
    return r;
  endfunction

  // One-second decrement with borrow s0 -> s1 -> m0 -> m1. 00:00 stays 00:00.
  function automatic mmss_t bcd_dec(input mmss_t v);
    mmss_t r;
    r = v;
    if (v.s0 != 4'd0) r.s0 = v.s0 - 4'd1;
    else begin
      r.s0 = BCD_MAX_UNITS;
      if (v.s1 != 4'd0) r.s1 = v.s1 - 4'd1;
      else begin
        r.s1 = BCD_MAX_TENS_SEC;
        if (v.m0 != 4'd0) r.m0 = v.m0 - 4'd1;
        else begin
          r.m0 = BCD_MAX_UNITS;
          if (v.m1 != 4'd0) r.m1 = v.m1 - 4'd1;
          else r = '0;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/countdown_sequencer_if.sv
// Control/status bundle between the set-value/button logic and the
// countdown sequencer.
//   master: drives load/start/pause pulses and set_* digits, observes status
//   slave : the sequencer; drives m1..s0 digits, running/paused/alarm, tick
interface countdown_sequencer_if;
  logic       load;
  logic       start;
  logic       pause;
  logic [3:0] set_m1, set_m0, set_s1, set_s0;
  logic [3:0] m1, m0, s1, s0;
  logic       running;
  logic       paused;
  logic       alarm;
  logic       tick;

  modport master (
    output load, start, pause, set_m1, set_m0, set_s1, set_s0,
    input  m1, m0, s1, s0, running, paused, alarm, tick
  );

  modport slave (
    input  load, start, pause, set_m1, set_m0, set_s1, set_s0,
    output m1, m0, s1, s0, running, paused, alarm, tick
  );
endinterface

// File: rtl/countdown_sequencer_tick_prescaler.sv
// 1-of-CLK_HZ strobe generator.
//   clk, reset : clock, async active-high reset
//   enable     : count advances only while high; otherwise the count holds
//   clear      : synchronous restart of the second (wins over enable)
//   tick       : high for the enabled cycle in which the count sits at CLK_HZ-1
module tick_prescaler #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);
  localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       cnt <= '0;
    else if (clear)  cnt <= '0;
    else if (enable) cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
  end

  assign tick = enable & (cnt == LAST);
endmodule

// File: rtl/countdown_sequencer.sv
// MM:SS egg-timer countdown sequencer.
//   clk, reset : system clock, async active-high reset
//   bus        : slave side of countdown_sequencer_if (load/start/pause
//                pulses and set digits in; BCD digits, status, tick out)
// Loads clamped set digits, counts down once per CLK_HZ cycles with BCD
// borrow, supports pause/resume, and holds ALARM for ALARM_SECS seconds.
module countdown_sequencer
  import countdown_sequencer_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int ALARM_SECS = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  countdown_sequencer_if.slave  bus
);
  localparam int AW = (ALARM_SECS > 0) ? $clog2(ALARM_SECS + 1) : 1;
  localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_SECS - 1);

  state_t        state, state_nxt;
  mmss_t         dig, dig_nxt, dig_dec, set_v;
  logic          pre_en, pre_clr, pre_tick;
  logic [AW-1:0] acnt;
  logic          running_q, paused_q, alarm_q;

  assign set_v   = {bus.set_m1, bus.set_m0, bus.set_s1, bus.set_s0};
  assign dig_dec = bcd_dec(dig);
  // Count holds in PAUSE so a resume finishes the interrupted second.
  assign pre_en  = (state == ST_RUN) || (state == ST_ALARM);

  tick_prescaler #(.CLK_HZ(CLK_HZ)) u_pre (
    .clk    (clk),
    .reset  (reset),
    .enable (pre_en),
    .clear  (pre_clr),
    .tick   (pre_tick)
  );

  always_comb begin
    state_nxt = state;
    dig_nxt   = dig;
    pre_clr   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.load) begin
          state_nxt = ST_LOADED;
          dig_nxt   = clamp_mmss(set_v);
        end
      end
      ST_LOADED, ST_PAUSE: begin
        if (bus.load) begin
          state_nxt = ST_LOADED;
          dig_nxt   = clamp_mmss(set_v);
        end else if (bus.start && (dig != '0)) begin
          state_nxt = ST_RUN;
          pre_clr   = (state == ST_LOADED);  // fresh run starts a whole second
        end
      end
      ST_RUN: begin
        // A tick coinciding with pause still lands its decrement; reaching
        // 00:00 overrides the pause so the timer cannot park at zero.
        if (pre_tick) begin
          dig_nxt = dig_dec;
          if (dig_dec == '0) begin
            state_nxt = ST_ALARM;
            pre_clr   = 1'b1;
          end else if (bus.pause) begin
            state_nxt = ST_PAUSE;
          end
        end else if (bus.pause) begin
          state_nxt = ST_PAUSE;
        end
      end
      ST_ALARM: begin
        if (bus.start || bus.load)                 state_nxt = ST_IDLE;
        else if (pre_tick && (acnt == ALARM_LAST)) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      dig       <= '0;
      acnt      <= '0;
      running_q <= 1'b0;
      paused_q  <= 1'b0;
      alarm_q   <= 1'b0;
    end else begin
      state     <= state_nxt;
      dig       <= dig_nxt;
      running_q <= (state_nxt == ST_RUN);
      paused_q  <= (state_nxt == ST_PAUSE);
      alarm_q   <= (state_nxt == ST_ALARM);
      if ((state_nxt == ST_ALARM) && (state != ST_ALARM)) acnt <= '0;
      else if ((state == ST_ALARM) && pre_tick)           acnt <= acnt + 1'b1;
    end
  end

  assign bus.m1      = dig.m1;
  assign bus.m0      = dig.m0;
  assign bus.s1      = dig.s1;
  assign bus.s0      = dig.s0;
  assign bus.running = running_q;
  assign bus.paused  = paused_q;
  assign bus.alarm   = alarm_q;
  assign bus.tick    = pre_tick;
endmodule
